// File: rtl/divider_iter_pkg.sv
// Shared constants for the iterative divider: op encodings, FSM state codes
// and small op-decode helpers.
package divider_iter_pkg;

  localparam logic [1:0] DIV_DIV  = 2'd0;
  localparam logic [1:0] DIV_DIVU = 2'd1;
  localparam logic [1:0] DIV_REM  = 2'd2;
  localparam logic [1:0] DIV_REMU = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == DIV_DIV) || (op == DIV_REM);
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == DIV_REM) || (op == DIV_REMU);
  endfunction

endpackage

// File: rtl/divider_iter.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: one quotient bit per
// cycle, with divide-by-zero and signed overflow resolved at accept.
module divider_iter
  import divider_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             div_valid,
  input  logic [1:0]       div_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             div_busy,
  output logic             div_done,
  output logic [WIDTH-1:0] div_result
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvsr;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [1:0]       r_op;

  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic             w_div0;
  logic             w_ovf;
  logic             w_accept;
  logic [WIDTH:0]   w_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_step_rem;
  logic [WIDTH-1:0] w_step_quo;
  logic [WIDTH-1:0] w_raw;
  logic             w_neg;

  assign w_signed = op_is_signed(div_op);
  assign w_a_neg  = w_signed & dividend[WIDTH-1];
  assign w_b_neg  = w_signed & divisor[WIDTH-1];
  assign w_abs_a  = w_a_neg ? (~dividend + ONE) : dividend;
  assign w_abs_b  = w_b_neg ? (~divisor + ONE) : divisor;
  assign w_div0   = (divisor == ZERO);
  assign w_ovf    = w_signed && (dividend == MIN_NEG) && (divisor == ALL_ONES);
  assign w_accept = (r_state == ST_IDLE) && div_valid && !flush;

  // Restoring step: the borrow out of the (WIDTH+1)-bit subtract is the compare.
  assign w_sh       = {r_rem, r_quo[WIDTH-1]};
  assign w_diff     = w_sh - {1'b0, r_dvsr};
  assign w_ge       = ~w_diff[WIDTH];
  assign w_step_rem = w_ge ? w_diff[WIDTH-1:0] : w_sh[WIDTH-1:0];
  assign w_step_quo = {r_quo[WIDTH-2:0], w_ge};

  // Result is decoded from held state only, so it stays put until the next accept.
  assign w_raw      = op_is_rem(r_op) ? r_rem : r_quo;
  assign w_neg      = op_is_rem(r_op) ? r_neg_r : r_neg_q;
  assign div_result = w_neg ? (~w_raw + ONE) : w_raw;
  assign div_busy   = (r_state == ST_CALC);
  assign div_done   = (r_state == ST_DONE) && !flush;

  // FSM, iteration counter and datapath registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvsr  <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_op    <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op   <= div_op;
            r_dvsr <= w_abs_b;
            if (w_div0) begin
              r_quo   <= ALL_ONES;
              r_rem   <= dividend;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
              r_state <= ST_DONE;
            end else if (w_ovf) begin
              r_quo   <= MIN_NEG;
              r_rem   <= ZERO;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
              r_state <= ST_DONE;
            end else begin
              r_quo   <= w_abs_a;
              r_rem   <= ZERO;
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
              r_cnt   <= CNT_W'(WIDTH - 1);
              r_state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (flush) begin
            r_state <= ST_IDLE;
          end else begin
            r_quo <= w_step_quo;
            r_rem <= w_step_rem;
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == '0) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_iter.sv
// Scoreboard bench for divider_iter: directed vectors push expected results,
// a negedge monitor pops and checks result, latency and busy behaviour.
module tb_divider_iter;
  import divider_iter_pkg::*;

  logic        clk;
  logic        nrst;
  logic        div_valid;
  logic [1:0]  div_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_result;

  typedef struct {
    string       name;
    logic [31:0] res;
    int          acc_cyc;
    int          lat;
    logic        busy;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  logic prev_busy = 1'b0;

  divider_iter #(.WIDTH(32)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .div_valid  (div_valid),
    .div_op     (div_op),
    .dividend   (dividend),
    .divisor    (divisor),
    .flush      (flush),
    .div_busy   (div_busy),
    .div_done   (div_done),
    .div_result (div_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endfunction

  // Monitor: every div_done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (div_done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_done", {31'd0, div_done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_result"}, div_result, e.res);
        chk({e.name, "_latency"}, cyc - e.acc_cyc, e.lat);
        chk({e.name, "_busy_before"}, {31'd0, prev_busy}, {31'd0, e.busy});
        chk({e.name, "_busy_at_done"}, {31'd0, div_busy}, 32'd0);
      end
    end
    prev_busy <= div_busy;
  end

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk); #1;
    div_valid = 1'b1;
    div_op    = op;
    dividend  = a;
    divisor   = b;
    @(negedge clk); #1;
    div_valid = 1'b0;
  endtask

  task automatic issue(input string nm, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input int lat);
    exp_t e;
    @(negedge clk); #1;
    div_valid = 1'b1;
    div_op    = op;
    dividend  = a;
    divisor   = b;
    e.name    = nm;
    e.res     = res;
    e.acc_cyc = cyc;
    e.lat     = lat;
    e.busy    = (lat != 1);
    sb.push_back(e);
    @(negedge clk); #1;
    div_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb.size() == 0) return;
    end
    chk("timeout_outstanding", sb.size(), 32'd0);
    sb.delete();
  endtask

  initial begin
    nrst      = 1'b1;
    div_valid = 1'b0;
    div_op    = DIV_DIV;
    dividend  = 32'd0;
    divisor   = 32'd0;
    flush     = 1'b0;
    #1 nrst = 1'b0;
    #2;
    chk("reset_busy", {31'd0, div_busy}, 32'd0);
    chk("reset_done", {31'd0, div_done}, 32'd0);
    chk("reset_result", div_result, 32'd0);
    repeat (2) @(negedge clk);
    #1 nrst = 1'b1;

    issue("div_20_m3",    DIV_DIV,  32'd20,         32'hFFFF_FFFD, 32'hFFFF_FFFA, 33);
    wait_idle(60);
    issue("rem_20_m3",    DIV_REM,  32'd20,         32'hFFFF_FFFD, 32'h0000_0002, 33);
    wait_idle(60);
    issue("rem_m20_3",    DIV_REM,  32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE, 33);
    wait_idle(60);
    issue("divu_max_1",   DIV_DIVU, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 33);
    wait_idle(60);
    issue("remu_max_16",  DIV_REMU, 32'hFFFF_FFFF,  32'h10,        32'h0000_000F, 33);
    wait_idle(60);
    issue("div_m7_2",     DIV_DIV,  32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
    wait_idle(60);
    issue("div_5_0",      DIV_DIV,  32'd5,          32'd0,         32'hFFFF_FFFF, 1);
    wait_idle(10);
    issue("remu_7_0",     DIV_REMU, 32'd7,          32'd0,         32'd7,         1);
    wait_idle(10);
    issue("div_ovf",      DIV_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
    wait_idle(10);
    issue("rem_ovf",      DIV_REM,  32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);
    wait_idle(10);

    // Flush in the tenth CALC cycle: no pulse may follow.
    drive(DIV_DIVU, 32'd1000, 32'd3);
    repeat (9) begin @(negedge clk); #1; end
    chk("flush_busy_before", {31'd0, div_busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk); #1;
    flush = 1'b0;
    chk("flush_busy_after", {31'd0, div_busy}, 32'd0);
    repeat (40) @(negedge clk);
    issue("divu_100_7",   DIV_DIVU, 32'd100,        32'd7,         32'd14,        33);
    wait_idle(60);

    // Asynchronous reset in the middle of CALC.
    drive(DIV_DIVU, 32'd1000, 32'd7);
    repeat (5) begin @(negedge clk); #1; end
    chk("midcalc_busy", {31'd0, div_busy}, 32'd1);
    nrst = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, div_busy}, 32'd0);
    chk("midrst_done", {31'd0, div_done}, 32'd0);
    chk("midrst_result", div_result, 32'd0);
    @(negedge clk); #1;
    nrst = 1'b1;
    repeat (40) @(negedge clk);

    // div_valid held through the whole operation must produce a single accept.
    begin
      exp_t e;
      int   seen;
      @(negedge clk); #1;
      div_valid = 1'b1;
      div_op    = DIV_DIVU;
      dividend  = 32'd50;
      divisor   = 32'd5;
      e.name    = "divu_held";
      e.res     = 32'd10;
      e.acc_cyc = cyc;
      e.lat     = 33;
      e.busy    = 1'b1;
      sb.push_back(e);
      seen = 0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (div_done === 1'b1) begin
          seen = 1;
          break;
        end
      end
      #1 div_valid = 1'b0;
      chk("held_done_seen", seen, 32'd1);
      repeat (40) @(negedge clk);
      chk("held_outstanding", sb.size(), 32'd0);
    end

    // Back-to-back requests with no idle gap beyond the required one.
    issue("div_b2b_a",    DIV_DIV,  32'd9,          32'd3,         32'd3,         33);
    wait_idle(60);
    issue("rem_b2b_b",    DIV_REM,  32'd9,          32'd4,         32'd1,         33);
    wait_idle(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/divider_iter.md
DIVIDER_ITER -- requirements
Module: divider_iter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port nrst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port div_valid, input, 1 bit: request from the decode stage for DIV/DIVU/REM/REMU.
REQ-005 The block SHALL have port div_op, input, 2 bits: operation select, 0 DIV, 1 DIVU, 2 REM, 3 REMU.
REQ-006 The block SHALL have port dividend, input, WIDTH bits: forwarded rs1 value.
REQ-007 The block SHALL have port divisor, input, WIDTH bits: forwarded rs2 value.
REQ-008 The block SHALL have port flush, input, 1 bit: pipeline flush; aborts any operation in progress.
REQ-009 The block SHALL have port div_busy, output, 1 bit: stall request to the pipeline.
REQ-010 The block SHALL have port div_done, output, 1 bit: single-cycle result-valid pulse.
REQ-011 The block SHALL have port div_result, output, WIDTH bits: quotient or remainder, routed to the WB mux (sel_data 4).

Function
REQ-012 The block SHALL implement an FSM with three states: IDLE, CALC and DONE.
REQ-013 A request SHALL be accepted only in IDLE when div_valid=1 and flush=0; div_valid in any other state SHALL be ignored.
REQ-014 On accept, the block SHALL latch: |dividend| and |divisor| for signed ops (raw values for unsigned), quotient-negate flag (signs differ, signed op), remainder-negate flag (dividend negative, signed op), and div_op.
REQ-015 For a normal accept, the block SHALL load counter=WIDTH-1 and enter CALC.
REQ-016 In CALC, each cycle SHALL perform one restoring shift-subtract step: shift {rem,quo} left by 1; if rem >= divisor, subtract divisor and set quo LSB to 1.
REQ-017 In CALC, after the step with counter=0 the FSM SHALL enter DONE, giving exactly WIDTH CALC cycles.
REQ-018 Divide-by-zero SHALL be detected at accept and SHALL skip CALC, entering DONE on the next edge with quo=all ones, rem=raw dividend, and both negate flags cleared.
REQ-019 Signed overflow (DIV/REM with dividend=0x80000000, divisor=0xFFFFFFFF) SHALL be detected at accept and SHALL skip CALC, entering DONE with quo=0x80000000, rem=0, and flags cleared.
REQ-020 In DONE, div_done SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-021 div_result SHALL equal the sign-corrected quo for ops 0/1 and the sign-corrected rem for ops 2/3, and SHALL hold stable from DONE until the next accept.
REQ-022 Latency from the accept edge to the div_done cycle SHALL be WIDTH+1 cycles for normal operations and 1 cycle for the special cases.
REQ-023 div_busy SHALL be 1 in CALC and SHALL be 0 in IDLE and DONE, so the requesting instruction stalls until the DONE cycle.
REQ-024 flush in CALC or DONE SHALL force IDLE on the next edge with div_done=0; flush in DONE SHALL suppress the pulse.
REQ-025 flush and div_valid asserted together in IDLE SHALL result in no accept.
REQ-026 A new request SHALL be acceptable in the cycle after DONE, with no dead cycles.

Reset
REQ-027 While nrst=0, the block SHALL asynchronously set state=IDLE and clear counter, quo, rem, flags, div_done, div_busy and div_result to 0.
REQ-028 Reset mid-CALC SHALL discard the operation; no div_done SHALL follow.

Structure
REQ-029 The div_op encodings (DIV_DIV, DIV_DIVU, DIV_REM, DIV_REMU) and FSM state codes SHALL live in the shared constants header alongside the ALU/atomic op codes.
REQ-030 The block SHALL be a single module with no sub-module; the counter width SHALL be $clog2(WIDTH).

Verification
REQ-031 The bench SHALL check: DIV 20 / -3 -> div_done 33 cycles after accept, div_result 0xFFFFFFFA; REM with the same operands -> 0x00000002.
REQ-032 The bench SHALL check: REM -20 / 3 -> 0xFFFFFFFE; DIVU 0xFFFFFFFF / 1 -> 0xFFFFFFFF; REMU 0xFFFFFFFF / 0x10 -> 0x0000000F.
REQ-033 The bench SHALL check: DIV 5 / 0 -> 0xFFFFFFFF and REMU 7 / 0 -> 7, each with done 1 cycle after accept and div_busy never high.
REQ-034 The bench SHALL check: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, and REM with the same operands -> 0, each with latency 1.
REQ-035 The bench SHALL check: flush on CALC cycle 10 -> IDLE next cycle, no div_done; then DIVU 100 / 7 -> 14 with normal latency.
REQ-036 The bench SHALL check: nrst pulsed low mid-CALC -> all outputs 0 immediately, no spurious div_done; div_valid held high while busy -> exactly one accept.
